demux_dispatch_ctrl: RTL and testbench

//  Sequences an 8-bit input stream onto four output channels (a..d) with per-channel valid/ready handshakes.

---
 rtl/demux_dispatch_ctrl.sv | 95 +++++++++
 tb/tb_demux_dispatch_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: 4-way demux with addressed/round-robin dispatch, flush drain FSM, optional DEMUX_DISPATCH_STATS_EN counters
module demux_dispatch_ctrl #(
`ifdef DEMUX_DISPATCH_STATS_EN
   parameter int DATA_W = 8,
   parameter int CNT_W = 8
`else
   parameter int DATA_W = 8
`endif
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        dest_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              mode_i,
   input  logic              flush_i,
   output logic              flush_done_o,
   output logic [DATA_W-1:0] data_a_o,
   output logic [DATA_W-1:0] data_b_o,
   output logic [DATA_W-1:0] data_c_o,
   output logic [DATA_W-1:0] data_d_o,
   output logic              valid_a_o,
   output logic              valid_b_o,
   output logic              valid_c_o,
   output logic              valid_d_o,
   input  logic              ready_a_i,
   input  logic              ready_b_i,
   input  logic              ready_c_i,
   input  logic              ready_d_i
`ifdef DEMUX_DISPATCH_STATS_EN
   ,
   input  logic [1:0]        stat_sel_i,
   output logic [CNT_W-1:0]  stat_cnt_o
`endif
);
   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
   state_t state, state_n;
   logic [DATA_W-1:0] dq [4];
   logic [3:0] vld, rdy, free;
   logic [1:0] rr_ptr, rr_k, tgt;
   logic rr_ok, acc;
   assign rdy = {ready_d_i, ready_c_i, ready_b_i, ready_a_i};
   assign free = ~vld | rdy;
   always_comb begin
      rr_ok = 1'b0;
      rr_k = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         if (free[rr_ptr + 2'(i)]) begin
            rr_ok = 1'b1;
            rr_k = rr_ptr + 2'(i);
         end
      end
   end
   assign tgt = mode_i ? rr_k : dest_i;
   assign ready_o = (state == RUN) & (mode_i ? rr_ok : free[dest_i]);
   assign acc = valid_i & ready_o;
   assign flush_done_o = state == DONE;
   always_comb begin
      state_n = (state == RUN) ? (flush_i ? DRAIN : RUN) :
                (state == DRAIN) ? (|vld ? DRAIN : DONE) : RUN;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RUN;
         rr_ptr <= 2'd3;
         vld <= '0;
         for (int k = 0; k < 4; k++) dq[k] <= '0;
      end else begin
         state <= state_n;
         if (acc & mode_i) rr_ptr <= rr_k;
         for (int k = 0; k < 4; k++) begin
            if (acc && tgt == 2'(k)) begin
               dq[k] <= data_i;
               vld[k] <= 1'b1;
            end else if (rdy[k]) begin
               vld[k] <= 1'b0;
            end
         end
      end
   end
   assign {data_d_o, data_c_o, data_b_o, data_a_o} = {dq[3], dq[2], dq[1], dq[0]};
   assign {valid_d_o, valid_c_o, valid_b_o, valid_a_o} = vld;
`ifdef DEMUX_DISPATCH_STATS_EN
   logic [CNT_W-1:0] cnt [4];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < 4; k++) cnt[k] <= '0;
      end else if (acc && cnt[tgt] != '1) begin
         cnt[tgt] <= cnt[tgt] + CNT_W'(1);
      end
   end
   assign stat_cnt_o = cnt[stat_sel_i];
`endif
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: directed and random stimulus against a behavioural dispatch model
module tb_demux_dispatch_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, vin, mode, flush, rdy_o, done_o;
   logic [7:0] din;
   logic [1:0] dest;
   logic [3:0] rdy;
   logic [7:0] da, db, dc, dd;
   logic va, vb, vc, vd;
`ifdef DEMUX_DISPATCH_STATS_EN
   logic [1:0] sel;
   logic [7:0] scnt;
`endif
   demux_dispatch_ctrl dut (
      .clk_i(clk), .rst_i(rst), .data_i(din), .dest_i(dest), .valid_i(vin),
      .ready_o(rdy_o), .mode_i(mode), .flush_i(flush), .flush_done_o(done_o),
      .data_a_o(da), .data_b_o(db), .data_c_o(dc), .data_d_o(dd),
      .valid_a_o(va), .valid_b_o(vb), .valid_c_o(vc), .valid_d_o(vd),
      .ready_a_i(rdy[0]), .ready_b_i(rdy[1]), .ready_c_i(rdy[2]), .ready_d_i(rdy[3])
`ifdef DEMUX_DISPATCH_STATS_EN
      , .stat_sel_i(sel), .stat_cnt_o(scnt)
`endif
   );
   int total = 0, bad = 0;
   bit m_vld [4];
   logic [7:0] m_dat [4];
   int m_cnt [4];
   int m_ptr, m_st;
   bit stalled;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [7:0] dut_data(int k);
      return k == 0 ? da : k == 1 ? db : k == 2 ? dc : dd;
   endfunction
   function automatic bit m_free(int k);
      return !m_vld[k] || rdy[k];
   endfunction
   task automatic m_reset();
      for (int k = 0; k < 4; k++) begin
         m_vld[k] = 0;
         m_dat[k] = 8'h00;
         m_cnt[k] = 0;
      end
      m_ptr = 3;
      m_st = 0;
      stalled = 0;
   endtask
   task automatic cycle();
      int t;
      bit any, er, acc, busy;
      @(negedge clk);
      t = -1;
      for (int i = 1; i <= 4; i++) if (t < 0 && m_free((m_ptr + i) % 4)) t = (m_ptr + i) % 4;
      any = t >= 0;
      if (!mode) t = dest;
      er = m_st == 0 && (mode ? any : m_free(dest));
      chk("ready_o", rdy_o, er);
      chk("flush_done", done_o, m_st == 2);
      chk("valid", {vd, vc, vb, va}, {m_vld[3], m_vld[2], m_vld[1], m_vld[0]});
      for (int k = 0; k < 4; k++) chk($sformatf("data%0d", k), dut_data(k), m_dat[k]);
`ifdef DEMUX_DISPATCH_STATS_EN
      chk("stat_cnt", scnt, m_cnt[sel]);
`endif
      acc = vin && er;
      stalled = vin && !er;
      busy = m_vld[0] || m_vld[1] || m_vld[2] || m_vld[3];
      m_st = m_st == 0 ? (flush ? 1 : 0) : m_st == 1 ? (busy ? 1 : 2) : 0;
      for (int k = 0; k < 4; k++) begin
         if (acc && t == k) begin
            m_dat[k] = din;
            m_vld[k] = 1;
            if (m_cnt[k] < 255) m_cnt[k]++;
         end else if (rdy[k]) m_vld[k] = 0;
      end
      if (acc && mode) m_ptr = t;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1;
      vin = 0;
      flush = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      m_reset();
   endtask
   int order [5] = '{0, 1, 3, 0, 1};
   initial begin
      rst = 1; vin = 0; mode = 0; flush = 0; din = 0; dest = 0; rdy = 4'hF;
`ifdef DEMUX_DISPATCH_STATS_EN
      sel = 0;
`endif
      do_reset();
      chk("rst_ready", rdy_o, 1);
      chk("rst_valid", {vd, vc, vb, va}, 0);
      chk("rst_data", {dd, dc, db, da}, 0);
      chk("rst_done", done_o, 0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         din = 8'(8'h11 * (i + 1));
         dest = 2'(i);
         vin = 1;
         cycle();
         chk("t2_lat", dut_data(i), 8'h11 * (i + 1));
      end
      vin = 0;
      rdy = 4'b1101;
      din = 8'h55; dest = 1; vin = 1;
      cycle();
      chk("t3_first", db, 8'h55);
      din = 8'h66;
      repeat (3) begin
         chk("t3_stall", rdy_o, 0);
         cycle();
         chk("t3_hold", db, 8'h55);
      end
      rdy = 4'hF;
      #1 chk("t3_go", rdy_o, 1);
      cycle();
      chk("t3_second", db, 8'h66);
      vin = 0;
      do_reset();
      rdy = 4'b1011;
      din = 8'hCC; dest = 2; vin = 1;
      cycle();
      mode = 1;
      for (int i = 0; i < 5; i++) begin
         din = 8'(8'hA0 + i);
         cycle();
         chk("t4_rr", dut_data(order[i]), 8'hA0 + i);
      end
      vin = 0; mode = 0;
      do_reset();
      rdy = 4'b0110;
      vin = 1; din = 8'h5A; dest = 0;
      cycle();
      din = 8'h5D; dest = 3;
      cycle();
      vin = 0; flush = 1;
      cycle();
      flush = 0;
      vin = 1; dest = 1;
      #1 chk("t5_rdy", rdy_o, 0);
      repeat (3) cycle();
      rdy[0] = 1;
      repeat (2) cycle();
      chk("t5_wait", done_o, 0);
      rdy[3] = 1;
      cycle();
      chk("t5_nodone", done_o, 0);
      cycle();
      chk("t5_done", done_o, 1);
      cycle();
      chk("t5_after", done_o, 0);
      vin = 0; flush = 1;
      cycle();
      flush = 0;
      chk("t5e_1", done_o, 0);
      cycle();
      chk("t5e_2", done_o, 1);
      cycle();
`ifdef DEMUX_DISPATCH_STATS_EN
      do_reset();
      rdy = 4'hF; vin = 1; dest = 0;
      repeat (300) begin
         din = 8'($urandom);
         cycle();
      end
      dest = 2;
      repeat (3) cycle();
      vin = 0;
      sel = 0;
      #1 chk("t6_sat", scnt, 8'hFF);
      sel = 2;
      #1 chk("t6_c", scnt, 8'h03);
      do_reset();
      chk("t6_rst", scnt, 8'h00);
`endif
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (!stalled) begin
            din = 8'($urandom);
            dest = 2'($urandom);
            vin = ($urandom % 4) != 0;
         end
         if ($urandom % 8 == 0) mode = 1'($urandom);
         flush = ($urandom % 40) == 0;
         rdy = 4'($urandom);
`ifdef DEMUX_DISPATCH_STATS_EN
         sel = 2'($urandom);
`endif
         if ($urandom % 300 == 0) do_reset();
         else cycle();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
